// File: rtl/sap_pkg.sv
// Shared SAP-1 front-panel definitions: button decoder state codes and
// default timing constants.
package sap_pkg;

    typedef enum logic [1:0] {
        ST_ARM     = 2'd0,
        ST_IDLE    = 2'd1,
        ST_PRESSED = 2'd2,
        ST_HELD    = 2'd3
    } btn_state_t;

    localparam int BTN_HOLD_CYCLES   = 12_000_000;
    localparam int BTN_REPEAT_CYCLES = 3_000_000;

    function automatic int btn_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_event_decoder.sv
// Turns a debounced active-low button level into press/release/hold/repeat
// strobes plus a registered "held" level.
module button_event_decoder
    import sap_pkg::*;
#(
    parameter int HOLD_CYCLES   = BTN_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = BTN_REPEAT_CYCLES,
    parameter int REPEAT_EN     = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic button_i,
    output logic press_o,
    output logic release_o,
    output logic hold_o,
    output logic repeat_o,
    output logic held_o
);

    localparam int MAX_CYCLES = btn_max(HOLD_CYCLES, REPEAT_CYCLES);
    localparam int CNT_W      = ($clog2(MAX_CYCLES) < 1) ? 1 : $clog2(MAX_CYCLES);

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    btn_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;
    logic             r_release;
    logic             r_hold;
    logic             r_repeat;
    logic             r_held;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_ARM;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_hold    <= 1'b0;
            r_repeat  <= 1'b0;
            r_held    <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_hold    <= 1'b0;
            r_repeat  <= 1'b0;

            case (r_state)
                // A button held through reset must be released before it counts.
                ST_ARM: begin
                    r_held <= 1'b0;
                    if (button_i) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end
                end

                ST_IDLE: begin
                    r_held <= 1'b0;
                    if (!button_i) begin
                        r_state <= ST_PRESSED;
                        r_cnt   <= '0;
                        r_press <= 1'b1;
                        r_held  <= 1'b1;
                    end
                end

                // Release is checked first so it wins over a terminal count.
                ST_PRESSED: begin
                    if (button_i) begin
                        r_state   <= ST_IDLE;
                        r_cnt     <= '0;
                        r_release <= 1'b1;
                        r_held    <= 1'b0;
                    end else if (r_cnt == HOLD_LAST) begin
                        r_state <= ST_HELD;
                        r_cnt   <= '0;
                        r_hold  <= 1'b1;
                        r_held  <= 1'b1;
                    end else begin
                        r_cnt  <= r_cnt + CNT_ONE;
                        r_held <= 1'b1;
                    end
                end

                ST_HELD: begin
                    if (button_i) begin
                        r_state   <= ST_IDLE;
                        r_cnt     <= '0;
                        r_release <= 1'b1;
                        r_held    <= 1'b0;
                    end else if (REPEAT_EN != 0 && r_cnt == REPEAT_LAST) begin
                        r_cnt    <= '0;
                        r_repeat <= 1'b1;
                        r_held   <= 1'b1;
                    end else begin
                        // With repeat disabled the count parks at its last value.
                        if (r_cnt != REPEAT_LAST) begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                        r_held <= 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_ARM;
                    r_cnt   <= '0;
                    r_held  <= 1'b0;
                end
            endcase
        end
    end

    assign press_o   = r_press;
    assign release_o = r_release;
    assign hold_o    = r_hold;
    assign repeat_o  = r_repeat;
    assign held_o    = r_held;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed vector bench for button_event_decoder (HOLD=8, REPEAT=4), plus a
// second instance with auto-repeat disabled.
module tb_button_event_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: auto-repeat enabled
    logic rst_a = 1'b1;
    logic btn_a = 1'b0;
    logic press_a, release_a, hold_a, repeat_a, held_a;

    button_event_decoder #(
        .HOLD_CYCLES  (8),
        .REPEAT_CYCLES(4),
        .REPEAT_EN    (1)
    ) dut_a (
        .clk      (clk),
        .rst      (rst_a),
        .button_i (btn_a),
        .press_o  (press_a),
        .release_o(release_a),
        .hold_o   (hold_a),
        .repeat_o (repeat_a),
        .held_o   (held_a)
    );

    // Instance B: auto-repeat disabled
    logic rst_b = 1'b1;
    logic btn_b = 1'b0;
    logic press_b, release_b, hold_b, repeat_b, held_b;

    button_event_decoder #(
        .HOLD_CYCLES  (8),
        .REPEAT_CYCLES(4),
        .REPEAT_EN    (0)
    ) dut_b (
        .clk      (clk),
        .rst      (rst_b),
        .button_i (btn_b),
        .press_o  (press_b),
        .release_o(release_b),
        .hold_o   (hold_b),
        .repeat_o (repeat_b),
        .held_o   (held_b)
    );

    // exp bits: {press, release, hold, repeat, held}
    typedef struct packed {
        logic       rst;
        logic       btn;
        logic [4:0] exp;
    } vec_t;

    localparam logic [4:0] E_NONE = 5'b00000;
    localparam logic [4:0] E_PRS  = 5'b10001;
    localparam logic [4:0] E_REL  = 5'b01000;
    localparam logic [4:0] E_HLD  = 5'b00101;
    localparam logic [4:0] E_RPT  = 5'b00011;
    localparam logic [4:0] E_HELD = 5'b00001;

    vec_t vecs[$];
    int   tests  = 0;
    int   failed = 0;

    task automatic add(input logic r, input logic b, input logic [4:0] e);
        vec_t v;
        v.rst = r;
        v.btn = b;
        v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end else begin
            $display("[TB] ok   %s: %0h", name, act);
        end
    endtask

    int hold_cnt_b;
    int repeat_cnt_b;
    int held_lo_b;
    int rel_early_b;
    int other_b;

    initial begin
        // 1: button low through and after reset is ignored until released
        for (int i = 0; i < 3; i++)  add(1'b1, 1'b0, E_NONE);
        for (int i = 0; i < 20; i++) add(1'b0, 1'b0, E_NONE);
        add(1'b0, 1'b1, E_NONE);
        add(1'b0, 1'b1, E_NONE);
        add(1'b0, 1'b0, E_PRS);
        add(1'b0, 1'b1, E_REL);
        // 2: short press of 3 cycles
        add(1'b0, 1'b0, E_PRS);
        add(1'b0, 1'b0, E_HELD);
        add(1'b0, 1'b0, E_HELD);
        add(1'b0, 1'b1, E_REL);
        add(1'b0, 1'b1, E_NONE);
        // 3: long press of 30 cycles: hold at +8, repeats every 4 afterwards
        for (int i = 0; i < 30; i++) begin
            if (i == 0)                          add(1'b0, 1'b0, E_PRS);
            else if (i == 8)                     add(1'b0, 1'b0, E_HLD);
            else if (i > 8 && ((i - 8) % 4) == 0) add(1'b0, 1'b0, E_RPT);
            else                                 add(1'b0, 1'b0, E_HELD);
        end
        add(1'b0, 1'b1, E_REL);
        add(1'b0, 1'b1, E_NONE);
        // 4: release on the terminal-count edge yields release only
        add(1'b0, 1'b0, E_PRS);
        for (int i = 1; i < 8; i++) add(1'b0, 1'b0, E_HELD);
        add(1'b0, 1'b1, E_REL);
        add(1'b0, 1'b1, E_NONE);
        add(1'b0, 1'b0, E_PRS);
        add(1'b0, 1'b1, E_REL);
        // 5: reset while HELD, no release, re-arm required
        add(1'b0, 1'b0, E_PRS);
        for (int i = 1; i < 8; i++) add(1'b0, 1'b0, E_HELD);
        add(1'b0, 1'b0, E_HLD);
        add(1'b0, 1'b0, E_HELD);
        add(1'b1, 1'b0, E_NONE);
        for (int i = 0; i < 3; i++) add(1'b0, 1'b0, E_NONE);
        add(1'b0, 1'b1, E_NONE);
        add(1'b0, 1'b0, E_PRS);
        add(1'b0, 1'b1, E_REL);
        add(1'b0, 1'b1, E_NONE);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst_a = vecs[i].rst;
            btn_a = vecs[i].btn;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d rst=%0b btn=%0b", i, vecs[i].rst, vecs[i].btn),
                  {27'd0, press_a, release_a, hold_a, repeat_a, held_a},
                  {27'd0, vecs[i].exp});
        end

        // 6: repeat disabled, 40 cycles low
        @(negedge clk);
        rst_b = 1'b1;
        btn_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);
        hold_cnt_b   = 0;
        repeat_cnt_b = 0;
        held_lo_b    = 0;
        rel_early_b  = 0;
        other_b      = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            btn_b = 1'b0;
            @(posedge clk);
            #1;
            if (hold_b)    hold_cnt_b++;
            if (repeat_b)  repeat_cnt_b++;
            if (!held_b)   held_lo_b++;
            if (release_b) rel_early_b++;
            if (i == 0 && !press_b) other_b++;
            if (i == 8 && !hold_b)  other_b++;
        end
        check("norpt hold count",        hold_cnt_b,   1);
        check("norpt repeat count",      repeat_cnt_b, 0);
        check("norpt held low cycles",   held_lo_b,    0);
        check("norpt early release",     rel_early_b,  0);
        check("norpt press/hold timing", other_b,      0);
        @(negedge clk);
        btn_b = 1'b1;
        @(posedge clk);
        #1;
        check("norpt release edge",
              {27'd0, press_b, release_b, hold_b, repeat_b, held_b}, {27'd0, E_REL});
        @(posedge clk);
        #1;
        check("norpt after release",
              {27'd0, press_b, release_b, hold_b, repeat_b, held_b}, {27'd0, E_NONE});

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
